// File: rtl/alsu_pipe.sv
// alsu_pipe: two-stage valid/ready ALSU (capture stage S1, result stage).
// Invalid requests are dropped, counted and announced on an LED blink.
module alsu_pipe #(
    parameter int WIDTH          = 3,
    parameter     INPUT_PRIORITY = "A",
    parameter     FULL_ADDER     = "ON",
    parameter int BLINK_CYCLES   = 8,
    parameter int LED_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           opcode,
    input  logic                 cin,
    input  logic                 serial_in,
    input  logic                 direction,
    input  logic                 red_op_A,
    input  logic                 red_op_B,
    input  logic                 bypass_A,
    input  logic                 bypass_B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 err,
    output logic [7:0]           err_cnt,
    output logic [LED_WIDTH-1:0] leds
);

    localparam bit PRI_A   = (INPUT_PRIORITY == "A");
    localparam bit USE_CIN = (FULL_ADDER == "ON");
    localparam int CW      = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_CYCLES - 1);

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_XOR = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_SHF = 3'd4;
    localparam logic [2:0] OP_ROT = 3'd5;

    typedef enum logic {S_RUN, S_BLINK} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       op;
        logic             cin;
        logic             sin;
        logic             dir;
        logic             red_a;
        logic             red_b;
        logic             byp_a;
        logic             byp_b;
    } s1_t;

    s1_t                r_s1;
    logic               r_s1_valid;
    logic               r_out_valid;
    logic [2*WIDTH-1:0] r_out;
    logic               r_err;
    logic [7:0]         r_err_cnt;
    state_t             r_state;
    logic [CW-1:0]      r_blink_cnt;

    s1_t                w_req;
    state_t             w_state_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic               w_s1_inv;
    logic               w_s1_adv;
    logic               w_drop;
    logic               w_accept;
    logic               w_cin;
    logic [WIDTH-1:0]   w_x;
    logic [WIDTH-1:0]   w_rsrc;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_res;

    always_comb begin
        w_req       = '0;
        w_req.a     = A;
        w_req.b     = B;
        w_req.op    = opcode;
        w_req.cin   = cin;
        w_req.sin   = serial_in;
        w_req.dir   = direction;
        w_req.red_a = red_op_A;
        w_req.red_b = red_op_B;
        w_req.byp_a = bypass_A;
        w_req.byp_b = bypass_B;
    end

    // Validity outranks bypass: a reduction flag only makes sense for AND/XOR.
    assign w_s1_inv = (r_s1.op[2:1] == 2'b11) ||
                      ((r_s1.red_a || r_s1.red_b) && (r_s1.op[2:1] != 2'b00));
    assign w_s1_adv = r_s1_valid && (!r_out_valid || out_ready);
    assign w_drop   = w_s1_adv && w_s1_inv;
    assign in_ready = (r_state == S_RUN) && rst && (!r_s1_valid || w_s1_adv);
    assign w_accept = in_valid && in_ready;

    assign w_x    = PRI_A ? r_s1.a : r_s1.b;
    assign w_rsrc = (r_s1.red_a && r_s1.red_b) ? w_x :
                    (r_s1.red_a ? r_s1.a : r_s1.b);
    assign w_cin  = USE_CIN ? r_s1.cin : 1'b0;
    assign w_sum  = {1'b0, r_s1.a} + {1'b0, r_s1.b} + {{WIDTH{1'b0}}, w_cin};
    assign w_prod = {{WIDTH{1'b0}}, r_s1.a} * {{WIDTH{1'b0}}, r_s1.b};

    always_comb begin
        w_res = '0;
        if (r_s1.byp_a || r_s1.byp_b) begin
            w_res[WIDTH-1:0] = (r_s1.byp_a && r_s1.byp_b) ? w_x :
                               (r_s1.byp_a ? r_s1.a : r_s1.b);
        end else begin
            unique case (r_s1.op)
                OP_AND: begin
                    if (r_s1.red_a || r_s1.red_b) w_res[0] = &w_rsrc;
                    else w_res[WIDTH-1:0] = r_s1.a & r_s1.b;
                end
                OP_XOR: begin
                    if (r_s1.red_a || r_s1.red_b) w_res[0] = ^w_rsrc;
                    else w_res[WIDTH-1:0] = r_s1.a ^ r_s1.b;
                end
                OP_ADD: w_res[WIDTH:0] = w_sum;
                OP_MUL: w_res = w_prod;
                OP_SHF: w_res[WIDTH-1:0] = r_s1.dir ?
                            {w_x[WIDTH-2:0], r_s1.sin} :
                            {r_s1.sin, w_x[WIDTH-1:1]};
                OP_ROT: w_res[WIDTH-1:0] = r_s1.dir ?
                            {w_x[WIDTH-2:0], w_x[WIDTH-1]} :
                            {w_x[0], w_x[WIDTH-1:1]};
                default: w_res = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1       <= w_req;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (w_s1_adv) begin
            r_out_valid <= !w_s1_inv;
            if (!w_s1_inv) r_out <= w_res;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err <= w_drop;
            if (w_drop && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_RUN;
            r_blink_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_blink_cnt <= w_cnt_nxt;
        end
    end

    // A drop seen while already blinking restarts the sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_blink_cnt;
        unique case (r_state)
            S_RUN: begin
                if (w_drop) begin
                    w_state_nxt = S_BLINK;
                    w_cnt_nxt   = '0;
                end
            end
            S_BLINK: begin
                if (w_drop) begin
                    w_cnt_nxt = '0;
                end else if (r_blink_cnt == CNT_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_blink_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;
    assign leds      = {LED_WIDTH{(r_state == S_BLINK) && !r_blink_cnt[0]}};

endmodule

// File: tb/tb_alsu_pipe.sv
// Scoreboard bench for alsu_pipe (WIDTH=4): directed vectors pushed on
// acceptance, a negedge monitor pops and compares on each output transfer.
module tb_alsu_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  A;
    logic [3:0]  B;
    logic [2:0]  opcode;
    logic        cin;
    logic        serial_in;
    logic        direction;
    logic        red_op_A;
    logic        red_op_B;
    logic        bypass_A;
    logic        bypass_B;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out;
    logic        err;
    logic [7:0]  err_cnt;
    logic [15:0] leds;

    int n_cmp;
    int n_bad;
    logic [7:0] q[$];

    alsu_pipe #(
        .WIDTH(4),
        .INPUT_PRIORITY("A"),
        .FULL_ADDER("ON"),
        .BLINK_CYCLES(8),
        .LED_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .A(A),
        .B(B),
        .opcode(opcode),
        .cin(cin),
        .serial_in(serial_in),
        .direction(direction),
        .red_op_A(red_op_A),
        .red_op_B(red_op_B),
        .bypass_A(bypass_A),
        .bypass_B(bypass_B),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out(out),
        .err(err),
        .err_cnt(err_cnt),
        .leds(leds)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: one pop per output transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got %h want none", out);
                end else begin
                    chk("result", {24'h0, out}, {24'h0, q.pop_front()});
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic c, input logic si,
                        input logic dir, input logic ra, input logic rb,
                        input logic ba, input logic bb, input bit push,
                        input logic [7:0] exp);
        bit ok;
        opcode    = op;
        A         = a;
        B         = b;
        cin       = c;
        serial_in = si;
        direction = dir;
        red_op_A  = ra;
        red_op_B  = rb;
        bypass_A  = ba;
        bypass_B  = bb;
        in_valid  = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("send_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) q.push_back(exp);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain", {31'h0, done}, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic blink_check(input logic [7:0] exp_cnt);
        @(negedge clk);
        chk("err_before_drop", {31'h0, err}, 0);
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("blink_leds", {16'h0, leds}, (i % 2 == 0) ? 32'hFFFF : 32'h0);
            chk("blink_in_ready", {31'h0, in_ready}, 0);
            chk("blink_out_valid", {31'h0, out_valid}, 0);
            if (i == 0) begin
                chk("err_pulse", {31'h0, err}, 1);
                chk("err_cnt", {24'h0, err_cnt}, {24'h0, exp_cnt});
            end else begin
                chk("err_low", {31'h0, err}, 0);
            end
        end
        @(negedge clk);
        chk("post_blink_leds", {16'h0, leds}, 0);
        chk("post_blink_ready", {31'h0, in_ready}, 1);
        chk("post_blink_cnt", {24'h0, err_cnt}, {24'h0, exp_cnt});
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        opcode    = '0;
        cin       = 1'b0;
        serial_in = 1'b0;
        direction = 1'b0;
        red_op_A  = 1'b0;
        red_op_B  = 1'b0;
        bypass_A  = 1'b0;
        bypass_B  = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'h0, out_valid}, 0);
        chk("rst_out", {24'h0, out}, 0);
        chk("rst_err", {31'h0, err}, 0);
        chk("rst_err_cnt", {24'h0, err_cnt}, 0);
        chk("rst_leds", {16'h0, leds}, 0);
        chk("rst_in_ready", {31'h0, in_ready}, 0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;

        // Throughput and latency
        send(3'd3, 4'hF, 4'h3, 0, 0, 0, 0, 0, 0, 0, 1, 8'h2D);
        chk("lat_not_yet", {31'h0, out_valid}, 0);
        send(3'd2, 4'hF, 4'hF, 1, 0, 0, 0, 0, 0, 0, 1, 8'h1F);
        chk("b2b_first_valid", {31'h0, out_valid}, 1);
        chk("b2b_first_out", {24'h0, out}, 32'h2D);
        @(posedge clk);
        #1;
        chk("b2b_second_valid", {31'h0, out_valid}, 1);
        chk("b2b_second_out", {24'h0, out}, 32'h1F);
        drain();

        // Backpressure
        out_ready = 1'b0;
        send(3'd3, 4'hF, 4'h3, 0, 0, 0, 0, 0, 0, 0, 1, 8'h2D);
        send(3'd2, 4'hF, 4'hF, 1, 0, 0, 0, 0, 0, 0, 1, 8'h1F);
        A        = 4'hC;
        B        = 4'hA;
        opcode   = 3'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'h0, out_valid}, 1);
            chk("bp_hold", {24'h0, out}, 32'h2D);
            chk("bp_in_ready", {31'h0, in_ready}, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(3'd0, 4'hC, 4'hA, 0, 0, 0, 0, 0, 0, 0, 1, 8'h08);
        drain();

        // Reduction / bypass / bitwise / add
        send(3'd1, 4'h7, 4'h0, 0, 0, 0, 1, 1, 0, 0, 1, 8'h01);
        send(3'd2, 4'h5, 4'h9, 0, 0, 0, 0, 0, 1, 1, 1, 8'h05);
        send(3'd2, 4'h5, 4'h9, 0, 0, 0, 0, 0, 0, 1, 1, 8'h09);
        send(3'd0, 4'h0, 4'hF, 0, 0, 0, 0, 1, 0, 0, 1, 8'h01);
        send(3'd1, 4'hC, 4'hA, 0, 0, 0, 0, 0, 0, 0, 1, 8'h06);
        send(3'd2, 4'h7, 4'h2, 0, 0, 0, 0, 0, 0, 0, 1, 8'h09);
        drain();

        // Shift / rotate
        send(3'd4, 4'h9, 4'h0, 0, 0, 1, 0, 0, 0, 0, 1, 8'h02);
        send(3'd5, 4'h9, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h0C);
        send(3'd5, 4'h9, 4'h0, 0, 0, 1, 0, 0, 0, 0, 1, 8'h03);
        send(3'd4, 4'h9, 4'h0, 0, 1, 0, 0, 0, 0, 0, 1, 8'h0C);
        direction = 1'b1;
        serial_in = 1'b0;
        A         = 4'h0;
        drain();

        // Invalid requests
        send(3'd6, 4'h1, 4'h2, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        blink_check(8'd1);
        send(3'd3, 4'h3, 4'h3, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00);
        blink_check(8'd2);

        // Reset mid-blink with the output full
        out_ready = 1'b0;
        send(3'd7, 4'h1, 4'h1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        send(3'd2, 4'h1, 4'h1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        @(negedge clk);
        chk("mid_leds_on", {16'h0, leds}, 32'hFFFF);
        chk("mid_err", {31'h0, err}, 1);
        chk("mid_err_cnt", {24'h0, err_cnt}, 3);
        @(negedge clk);
        chk("mid_out_full", {31'h0, out_valid}, 1);
        chk("mid_out", {24'h0, out}, 32'h02);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", {31'h0, out_valid}, 0);
        chk("arst_leds", {16'h0, leds}, 0);
        chk("arst_err_cnt", {24'h0, err_cnt}, 0);
        chk("arst_in_ready", {31'h0, in_ready}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        send(3'd3, 4'h5, 4'h6, 0, 0, 0, 0, 0, 0, 0, 1, 8'h1E);
        drain();
        chk("final_leds", {16'h0, leds}, 0);
        chk("final_queue", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alsu_pipe.md
# alsu_pipe

Parametrised, pipelined successor of the 3-bit ALSU. Performs AND/XOR (bitwise or reduction), add, multiply, shift and rotate on WIDTH-bit operands. Uses valid/ready handshakes on input and output, and sustains one operation per cycle. Invalid requests are dropped, counted and signalled on an LED blink sequence; the block sits between the switch/input capture logic and the display/LED drivers.

## Interface
- WIDTH, 3, operand width (2..16)
- INPUT_PRIORITY, "A", operand that wins when both bypass or both reduction flags are set; also the shift/rotate source ("A" or "B")
- FULL_ADDER, "ON", "ON" adds cin, "OFF" ignores it
- BLINK_CYCLES, 8, length of the LED blink sequence after an invalid request (>=1)
- LED_WIDTH, 16, LED bus width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- in_valid  in  1  request present
- in_ready  out  1  block accepts the request this cycle
- A, B  in  WIDTH  operands
- opcode  in  3  0 AND, 1 XOR, 2 ADD, 3 MUL, 4 SHIFT, 5 ROTATE, 6/7 invalid
- cin, serial_in, direction  in  1 each  carry-in, shift fill bit, 1 = left / 0 = right
- red_op_A, red_op_B, bypass_A, bypass_B  in  1 each  reduction and bypass selects
- out_valid  out  1  result present
- out_ready  in  1  consumer takes the result this cycle
- out  out  2*WIDTH  result, zero-extended
- err  out  1  one-cycle pulse per dropped invalid request
- err_cnt  out  8  saturating count of invalid requests
- leds  out  LED_WIDTH  blink indicator

## Operation
- Transfer occurs when in_valid && in_ready; all request fields, including direction, are captured together into stage S1.
- Invalid request: opcode 6 or 7, or (red_op_A || red_op_B) with opcode not 0/1.
  - The validity check takes precedence over bypass.
- Bypass takes precedence over the opcode.
  - bypass_A && bypass_B selects the operand named by INPUT_PRIORITY; otherwise the operand whose bypass is set.
- AND/XOR:
  - A single reduction flag reduces that operand to 1 bit.
  - Both flags set: reduce the INPUT_PRIORITY operand.
  - No flag set: bitwise A op B.
- ADD: A+B(+cin), WIDTH+1 bits. MUL: A*B, 2*WIDTH bits.
- SHIFT, on the priority operand X:
  - left gives {X[WIDTH-2:0], serial_in}
  - right gives {serial_in, X[WIDTH-1:1]}
- ROTATE, on X:
  - left gives {X[WIDTH-2:0], X[WIDTH-1]}
  - right gives {X[0], X[WIDTH-1:1]}
- FSM states:
  - RUN: normal pipeline operation.
  - BLINK: entered when an invalid S1 entry advances. The entry is discarded (no out_valid), err pulses, err_cnt increments (saturates at 255), and the blink counter clears.
  - In BLINK, leds = all ones on even counter values and all zeros on odd. After BLINK_CYCLES cycles leds returns to 0 and the FSM returns to RUN.
  - in_ready = 0 throughout BLINK. The output stage still drains normally.

## Timing
- Reset values: out_valid 0, out 0, err 0, err_cnt 0, leds 0, FSM RUN, S1 empty. in_ready is 0 while rst = 0.
- S1 advances when S1 is valid and (!out_valid || out_ready).
- in_ready = RUN && rst && (!S1 valid || S1 advances). in_ready is combinational and must not depend on in_valid.
- Latency: a request accepted at edge k appears with out_valid = 1 after edge k+1.
- Throughput: one request per cycle with out_ready held at 1.
- Backpressure: while out_valid && !out_ready, out holds stable and S1 holds. in_ready drops once S1 is full.
- Simultaneous drain and fill: out_valid stays 1, out updates, no bubble.
- Invalid entry advancing while the output drains: out_valid goes to 0 on that edge.
- The first BLINK cycle (leds all ones) follows the same edge on which err pulses.
- Reset mid-operation: S1, the output and the blink sequence are cleared immediately (asynchronously). In-flight results are lost.

## Test plan
- Throughput (WIDTH=4): back-to-back MUL A=F,B=3 then ADD A=F,B=F,cin=1 (FULL_ADDER="ON"), out_ready=1 -> out=0x2D, then 0x1F on consecutive cycles, latency 2.
- Backpressure: out_ready=0 for 3 cycles after the first result -> out held at 0x2D; in_ready=0 after S1 fills; no data lost once out_ready=1.
- Reduction/bypass (WIDTH=4, priority "A"):
  - XOR with red_op_A=red_op_B=1, A=7 -> out=1.
  - bypass_A=bypass_B=1, A=5, B=9 -> out=5.
- Shift/rotate (WIDTH=4), A=4'b1001:
  - shift left, serial_in=0 -> 0x2
  - rotate right -> 0xC
  - direction toggled after acceptance does not affect the result.
- Invalid request: opcode=6 -> no out_valid, one err pulse, err_cnt=1; leds toggle ones/zeros for 8 cycles with in_ready=0; leds=0 and in_ready=1 afterward. Separately, MUL with red_op_B=1 -> same error response.
- Reset mid-blink and with the output full -> out_valid=0, leds=0, err_cnt=0 immediately; normal operation resumes after rst returns to 1.
